// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: 2FF sync + clock filter, frame FSM with timeout, E0/F0 decoder, FWFT event FIFO (macro PS2_PARITY_CHECK_EN).
// Latency: ev_valid 3 clk after the stop-bit fall_edge; no PS/2 backpressure, a write into a full FIFO is dropped with an overflow pulse.
module ps2_rx_fifo #(
  parameter int FILTER_LEN      = 8,
  parameter int TIMEOUT_CYC     = 200000,
  parameter int FIFO_DEPTH      = 8,
  parameter int SUPPRESS_REPEAT = 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  output logic                          ev_valid,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_break,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ev_t;

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  logic          r_clk_filt;
  logic [FW-1:0] r_flt_cnt;
  logic          r_fall;
  logic          w_clk_s;
  logic          w_dat_s;

  assign w_clk_s = r_clk_sync[1];
  assign w_dat_s = r_dat_sync[1];

  // Idle PS/2 lines are high, so the synchronizers reset to 1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk};
      r_dat_sync <= {r_dat_sync[0], ps2_data};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_clk_filt <= 1'b1;
      r_flt_cnt  <= '0;
      r_fall     <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      if (w_clk_s == r_clk_filt) begin
        r_flt_cnt <= '0;
      end else if (r_flt_cnt == FW'(FILTER_LEN - 1)) begin
        r_clk_filt <= w_clk_s;
        r_flt_cnt  <= '0;
        r_fall     <= r_clk_filt;
      end else begin
        r_flt_cnt <= r_flt_cnt + 1'b1;
      end
    end
  end

  logic [1:0]    r_state;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic [TW-1:0] r_to_cnt;
  logic          r_byte_vld;
  logic          w_frame_ok;

`ifdef PS2_PARITY_CHECK_EN
  logic          r_par;
  assign w_frame_ok = w_dat_s & (^{r_shift, r_par});
`else
  assign w_frame_ok = w_dat_s;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_to_cnt   <= '0;
      r_byte_vld <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_byte_vld <= 1'b0;
      frame_err  <= 1'b0;
      if (r_fall) begin
        r_to_cnt <= '0;
        case (r_state)
          S_IDLE: begin
            if (!w_dat_s) begin
              r_state   <= S_DATA;
              r_bit_idx <= '0;
            end
          end
          S_DATA: begin
            r_shift <= {w_dat_s, r_shift[7:1]};
            if (r_bit_idx == 3'd7) r_state <= S_PARITY;
            else                   r_bit_idx <= r_bit_idx + 1'b1;
          end
          S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            r_par <= w_dat_s;
`endif
            r_state <= S_STOP;
          end
          default: begin
            r_byte_vld <= w_frame_ok;
            frame_err  <= ~w_frame_ok;
            r_state    <= S_IDLE;
          end
        endcase
      end else if (r_state != S_IDLE) begin
        // A keyboard that stops clocking mid-frame must not wedge the FSM.
        if (r_to_cnt == TW'(TIMEOUT_CYC - 1)) begin
          r_state   <= S_IDLE;
          frame_err <= 1'b1;
          r_to_cnt  <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end
    end
  end

  logic       r_ext_f;
  logic       r_brk_f;
  logic       r_last_vld;
  logic [8:0] r_last;
  logic       r_wr_vld;
  ev_t        r_wr_ev;
  logic       w_last_hit;
  logic       w_drop;

  assign w_last_hit = r_last_vld && (r_last == {r_ext_f, r_shift});
  assign w_drop     = (SUPPRESS_REPEAT != 0) && !r_brk_f && w_last_hit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ext_f    <= 1'b0;
      r_brk_f    <= 1'b0;
      r_last_vld <= 1'b0;
      r_last     <= '0;
      r_wr_vld   <= 1'b0;
      r_wr_ev    <= '0;
    end else begin
      r_wr_vld <= 1'b0;
      if (frame_err) begin
        r_ext_f <= 1'b0;
        r_brk_f <= 1'b0;
      end else if (r_byte_vld) begin
        if (r_shift == 8'hE0) begin
          r_ext_f <= 1'b1;
        end else if (r_shift == 8'hF0) begin
          r_brk_f <= 1'b1;
        end else begin
          r_ext_f  <= 1'b0;
          r_brk_f  <= 1'b0;
          r_wr_ev  <= {r_ext_f, r_brk_f, r_shift};
          r_wr_vld <= ~w_drop;
          if (SUPPRESS_REPEAT != 0) begin
            if (!r_brk_f) begin
              r_last_vld <= 1'b1;
              r_last     <= {r_ext_f, r_shift};
            end else if (w_last_hit) begin
              r_last_vld <= 1'b0;
            end
          end
        end
      end
    end
  end

  ev_t           r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  ev_t           w_head;

  assign w_full   = (fifo_count == (AW + 1)'(FIFO_DEPTH));
  assign w_pop    = rd_en && ev_valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push   = r_wr_vld && (!w_full || w_pop);
  assign ev_valid = (fifo_count != '0);
  assign w_head   = r_mem[r_rd_ptr];
  assign ev_code  = ev_valid ? w_head.code : 8'h00;
  assign ev_ext   = ev_valid & w_head.ext;
  assign ev_break = ev_valid & w_head.brk;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= r_wr_vld && w_full && !w_pop;
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_wr_ev;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: directed PS/2 frames push expected events, a monitor compares every FIFO pop.
module tb_ps2_rx_fifo;
  localparam int HALF = 100;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en = 1'b0;
  logic       rd_en2 = 1'b0;
  logic       ev_valid, ev_ext, ev_break, overflow, frame_err;
  logic [7:0] ev_code;
  logic [3:0] fifo_count;
  logic       ev_valid2, ev_ext2, ev_break2, overflow2, frame_err2;
  logic [7:0] ev_code2;
  logic [3:0] fifo_count2;

  ps2_rx_fifo #(.FILTER_LEN(4), .TIMEOUT_CYC(2000), .FIFO_DEPTH(8), .SUPPRESS_REPEAT(1)) u_dut (
    .clk(clk), .rstn(rstn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
    .ev_valid(ev_valid), .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break),
    .fifo_count(fifo_count), .overflow(overflow), .frame_err(frame_err)
  );

  ps2_rx_fifo #(.FILTER_LEN(4), .TIMEOUT_CYC(2000), .FIFO_DEPTH(8), .SUPPRESS_REPEAT(0)) u_dut_norep (
    .clk(clk), .rstn(rstn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en2),
    .ev_valid(ev_valid2), .ev_code(ev_code2), .ev_ext(ev_ext2), .ev_break(ev_break2),
    .fifo_count(fifo_count2), .overflow(overflow2), .frame_err(frame_err2)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_pass = 0;
  int         n_ferr = 0;
  int         n_ovf = 0;
  int         n_pop2 = 0;
  int         lat = 0;
  bit         auto_drain = 1'b0;
  bit         man_pop = 1'b0;
  logic [9:0] exp_q[$];

  task automatic chk(input string name, input int act, input int want);
    n_chk++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sole driver of rd_en/rd_en2, offset from the edge so the monitor sees settled values.
  initial forever begin
    @(posedge clk);
    #2;
    rd_en  = auto_drain ? ev_valid : man_pop;
    rd_en2 = ev_valid2;
  end

  initial forever begin
    @(negedge clk);
    if (frame_err) n_ferr++;
    if (overflow) n_ovf++;
    if (ev_valid2 && rd_en2) n_pop2++;
    if (ev_valid && rd_en) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_event: got 0x%0h expected none", {ev_ext, ev_break, ev_code});
      end else begin
        chk("event", int'({ev_ext, ev_break, ev_code}), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic send_frame(input logic [7:0] b, input int nbits, input logic par_flip,
                            input logic stop_b, input logic glitch, input logic pop_at_write);
    logic [10:0] bits;
    bits = {stop_b, (~^b) ^ par_flip, b, 1'b0};
    lat  = 0;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      tick(HALF);
      ps2_clk = 1'b0;
      for (int k = 1; k <= HALF; k++) begin
        tick(1);
        if (i == 10) begin
          if (ev_valid && lat == 0) lat = k;
          if (pop_at_write && k == 8) man_pop = 1'b1;
          if (pop_at_write && k == 9) man_pop = 1'b0;
        end
      end
      ps2_clk = 1'b1;
      if (glitch && i == 4) begin
        tick(30);
        ps2_clk = 1'b0;
        tick(2);
        ps2_clk = 1'b1;
      end
    end
    ps2_data = 1'b1;
    tick(HALF);
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 11, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic wait_drain(input string name);
    auto_drain = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      if (exp_q.size() == 0 && !ev_valid) break;
      tick(1);
    end
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int f0, o0, p0;
    logic [7:0] cs [10];
    cs = '{8'h15, 8'h16, 8'h1D, 8'h1E, 8'h24, 8'h25, 8'h26, 8'h2D, 8'h2E, 8'h36};

    tick(5);
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_outputs", int'({ev_code, ev_ext, ev_break, overflow, frame_err}), 0);
    rstn = 1'b1;
    tick(10);

    exp_q.push_back({2'b00, 8'h1D});
    good(8'h1D);
    chk("latency_1D", lat, 9);
    chk("count_1D", fifo_count, 1);
    chk("head_1D", ev_code, 8'h1D);
    man_pop = 1'b1;
    tick(1);
    man_pop = 1'b0;
    tick(2);
    chk("empty_after_pop", ev_valid, 0);

    f0 = n_ferr;
    auto_drain = 1'b1;
    exp_q.push_back({2'b10, 8'h75});
    exp_q.push_back({2'b11, 8'h75});
    good(8'hE0); good(8'h75); good(8'hE0); good(8'hF0); good(8'h75);
    wait_drain("ext");
    chk("ext_no_frame_err", n_ferr - f0, 0);

    p0 = n_pop2;
    exp_q.push_back({2'b00, 8'h1C});
    exp_q.push_back({2'b01, 8'h1C});
    exp_q.push_back({2'b00, 8'h1C});
    good(8'h1C); good(8'h1C); good(8'h1C); good(8'hF0); good(8'h1C); good(8'h1C);
    wait_drain("repeat");
    tick(20);
    chk("norepeat_events", n_pop2 - p0, 5);

    auto_drain = 1'b0;
    tick(2);
    o0 = n_ovf;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({2'b00, cs[i]});
      good(cs[i]);
    end
    good(cs[8]);
    chk("full_count", fifo_count, 8);
    chk("overflow_pulses", n_ovf - o0, 1);
    chk("full_head", ev_code, 8'h15);
    exp_q.push_back({2'b00, cs[9]});
    send_frame(cs[9], 11, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("pop_write_no_overflow", n_ovf - o0, 1);
    chk("pop_write_count", fifo_count, 8);
    wait_drain("fifo");

    f0 = n_ferr;
    send_frame(8'h00, 5, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1600);
    chk("no_early_timeout", n_ferr - f0, 0);
    tick(500);
    chk("timeout_frame_err", n_ferr - f0, 1);
    exp_q.push_back({2'b00, 8'h29});
    good(8'h29);
    wait_drain("after_timeout");
    chk("good_after_timeout", n_ferr - f0, 1);

    f0 = n_ferr;
    send_frame(8'h33, 11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(20);
    chk("stop0_frame_err", n_ferr - f0, 1);
    wait_drain("stop0");

    f0 = n_ferr;
`ifdef PS2_PARITY_CHECK_EN
    send_frame(8'h5A, 11, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_drain("parity");
    chk("parity_frame_err", n_ferr - f0, 1);
`else
    exp_q.push_back({2'b00, 8'h5A});
    send_frame(8'h5A, 11, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_drain("parity");
    chk("parity_ignored", n_ferr - f0, 0);
`endif

    f0 = n_ferr;
    exp_q.push_back({2'b00, 8'h4B});
    send_frame(8'h4B, 11, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_drain("glitch");
    chk("glitch_no_frame_err", n_ferr - f0, 0);

    auto_drain = 1'b0;
    tick(2);
    good(8'h1D);
    chk("pre_reset_count", fifo_count, 1);
    send_frame(8'h12, 6, 1'b0, 1'b1, 1'b0, 1'b0);
    f0 = n_ferr;
    rstn = 1'b0;
    tick(2);
    chk("midreset_ev_valid", ev_valid, 0);
    chk("midreset_count", fifo_count, 0);
    chk("midreset_outputs", int'({ev_code, ev_ext, ev_break, overflow, frame_err}), 0);
    rstn = 1'b1;
    tick(2500);
    chk("post_reset_no_frame_err", n_ferr - f0, 0);
    chk("post_reset_empty", ev_valid, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 keyboard receiver running entirely in the clk domain. It oversamples ps2_clk/ps2_data and deglitches the clock. It checks the frame (start, parity, stop, inactivity timeout) and decodes E0/F0 prefixes into make/break events with an extended flag. Events are buffered in a first-word-fall-through FIFO read by the game controller, replacing the single-scancode pulse interface.

Parameters:
FILTER_LEN, 8, consecutive identical ps2_clk samples required to change the filtered clock level (>=2)
TIMEOUT_CYC, 200000, clk cycles without a filtered falling edge before an in-progress frame is aborted (2 ms @100 MHz)
FIFO_DEPTH, 8, event FIFO entries; power of 2, >=2
SUPPRESS_REPEAT, 1, 1 = drop typematic repeats of the currently held make code; 0 = pass every make

Ports:
clk  in  1  system clock, 100 MHz
rstn  in  1  reset, asynchronous, active-low
ps2_clk  in  1  raw PS/2 clock line, asynchronous
ps2_data  in  1  raw PS/2 data line, asynchronous
rd_en  in  1  pop head event when ev_valid=1
ev_valid  out  1  FIFO non-empty; head event on ev_* outputs
ev_code  out  8  head event scan code
ev_ext  out  1  head event was E0-prefixed
ev_break  out  1  head event is a release (F0-prefixed)
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
overflow  out  1  1-cycle pulse: event dropped because FIFO full
frame_err  out  1  1-cycle pulse: bad start/stop/parity or timeout

Behaviour:
- Reset: all outputs 0, FIFO empty, decoder flags clear, FSM IDLE, filtered clock = 1, last-make invalid.
- Input path: ps2_clk and ps2_data each pass a 2-flop synchronizer. The filtered clock takes a new level only after FILTER_LEN consecutive agreeing synchronized samples. A fall_edge pulse (1 cycle) fires on a filtered 1->0 transition. Data is sampled on fall_edge.
- Frame FSM, advancing only on fall_edge:
  - IDLE: data=0 -> DATA with bit index 0. Data=1 -> stay IDLE, no error.
  - DATA: shift in LSB first; after 8 bits -> PARITY.
  - PARITY: capture the bit -> STOP.
  - STOP: data=1 and odd parity over 9 bits -> byte_valid pulse next cycle. Otherwise frame_err. Either way -> IDLE.
- Timeout: a counter clears on every fall_edge and counts while the FSM is not IDLE. Reaching TIMEOUT_CYC -> IDLE, frame_err pulse, partial byte discarded. The counter is idle in IDLE.
- Decoder, on byte_valid:
  - E0 sets ext_f.
  - F0 sets brk_f.
  - Any other byte forms event {ext_f, brk_f, byte}, then clears both flags.
  - A frame_err clears ext_f/brk_f.
- Repeat suppression (SUPPRESS_REPEAT=1):
  - A make equal to last_make {ext, code} is dropped.
  - Any other make is emitted and becomes last_make.
  - A break matching last_make invalidates it.
  - Breaks are always emitted.
- FIFO:
  - Event is written the cycle after byte_valid. ev_valid and head outputs update the following cycle.
  - Total latency: ev_valid high 3 clk after the stop-bit fall_edge cycle (empty FIFO).
  - Write when full: event dropped, overflow pulse, contents unchanged.
  - Simultaneous write and pop: both occur (also when full); count unchanged.
  - rd_en with ev_valid=0: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Asserting rstn mid-frame discards the frame and all FIFO contents immediately; no pulses are emitted.

Optional Feature:
Macro PS2_PARITY_CHECK_EN.
- Defined: odd-parity failure in STOP -> byte discarded, frame_err pulse.
- Undefined: parity bit is sampled but ignored; only start, stop and timeout generate frame_err.
- Ports are identical in both builds.

Test Plan:
(Bench parameters: FILTER_LEN=4, TIMEOUT_CYC=2000, PS/2 half-period 100 clk.)
- Send 0x1D frame (good parity, stop=1) -> ev_valid 3 clk after the stop fall_edge; ev_code=0x1D, ev_ext=0, ev_break=0, fifo_count=1. rd_en 1 cycle -> ev_valid=0.
- Send E0,75 then E0,F0,75 -> two events: {ext=1,brk=0,0x75} then {ext=1,brk=1,0x75}; no frame_err.
- Send 1C,1C,1C,F0,1C,1C with SUPPRESS_REPEAT=1 -> events 1C make, 1C break, 1C make (3 total). With SUPPRESS_REPEAT=0 -> 6 bytes give 5 events.
- Send 9 makes of distinct codes with FIFO_DEPTH=8 and no reads -> fifo_count=8, one overflow pulse, head = first code. Pop with rd_en held during the 9th write -> no overflow.
- Stop after 4 data bits, idle 2000 clk -> frame_err pulse, FSM IDLE. A following good 0x29 frame decodes correctly. Stop bit=0 -> frame_err, no event.
- Flip parity on 0x5A: macro defined -> frame_err, no event; undefined -> event 0x5A. 2-cycle glitch on ps2_clk -> no bit shifted. Assert rstn mid-frame -> all outputs 0.
